// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared FSM state type and default width for the serial adder
package serial_add_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam int DEF_WIDTH = 8;
endpackage

// File: rtl/half_adder.sv
// half_adder: 1-bit half adder
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

// File: rtl/serial_fa_cell.sv
// serial_fa_cell: combinational 1-bit full adder built from two half adders
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic s0, c0, c1;
  half_adder u_ha0 (.a(a), .b(b), .s(s0), .c(c0));
  half_adder u_ha1 (.a(s0), .b(cin), .s(s), .c(c1));
  assign cout = c0 | c1;
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller, one full-adder cell sequenced over WIDTH cycles
// Define SERIAL_ADD_OVF_EN to add the registered signed-overflow output ovf.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH);
  state_t state, state_n;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [CW-1:0] cnt;
  logic carry, s, c_nx, last;
  serial_fa_cell u_fa (.a(a_sh[0]), .b(b_sh[0]), .cin(carry), .s(s), .cout(c_nx));
  assign last = cnt == CW'(WIDTH - 1);
  assign busy = state == RUN;
  assign done = state == DONE;
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = IDLE;
    if (state == IDLE) state_n = start ? RUN : IDLE;
    else if (state == RUN) state_n = last ? DONE : RUN;
  end
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      sum <= '0;
      cout <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf <= 1'b0;
`endif
    end else if (state == IDLE && start) begin
      a_sh <= a;
      b_sh <= b;
      carry <= cin;
      cnt <= '0;
      sum <= '0;
    end else if (state == RUN) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      carry <= c_nx;
      cnt <= cnt + 1'b1;
      sum <= {s, sum[WIDTH-1:1]};
      if (last) cout <= c_nx;
`ifdef SERIAL_ADD_OVF_EN
      // on the MSB step, carry is the carry into the MSB
      if (last) ovf <= carry ^ c_nx;
`endif
    end
endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder controller.
- Sequences a single 1-bit full-adder cell, built from two half_adder instances, over WIDTH cycles to add two WIDTH-bit operands.
- Trades latency for area: the datapath is one adder cell regardless of WIDTH.
- Sits between an operand-issuing master (start/done handshake) and the shared adder cell.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).

Ports:
- clk    input   1      single clock; all state updates on rising edge
- rst    input   1      synchronous, active-high reset
- start  input   1      request; sampled only in IDLE
- a      input   WIDTH  operand A; captured on the accepted start
- b      input   WIDTH  operand B; captured on the accepted start
- cin    input   1      carry-in; captured on the accepted start
- busy   output  1      high while in RUN
- done   output  1      one-cycle pulse; sum/cout valid
- sum    output  WIDTH  result; holds until the next accepted start
- cout   output  1      final carry-out; holds with sum

Behaviour:
- Reset (rst=1 at an edge):
  - State goes to IDLE.
  - busy=0, done=0, sum=0, cout=0, bit counter=0.
  - Reset wins over every other input, including mid-RUN; the partial result is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - When start=1 at an edge: a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, sum<=0, state<=RUN.
  - Otherwise the state holds.
- RUN, each edge:
  - s = a_sh[0]^b_sh[0]^carry.
  - carry <= majority(a_sh[0], b_sh[0], carry).
  - sum <= {s, sum[WIDTH-1:1]}; a_sh and b_sh shift right by 1; cnt++.
  - When cnt==WIDTH-1 at the edge: state<=DONE and cout<=the new carry.
- DONE: done=1 for exactly this one cycle, then unconditionally IDLE.
- Latency: start accepted at edge E0; RUN occupies edges E1..E(WIDTH); done is high during the cycle after E(WIDTH). That is WIDTH+1 cycles from start to done, and a new start is accepted no earlier than the edge ending the DONE cycle + 1 (i.e. in IDLE).
- start in RUN or DONE is ignored and not queued. Operand changes after acceptance have no effect.
- Arithmetic:
  - Unsigned modulo 2^WIDTH; cout is the carry out of bit WIDTH-1.
  - {cout,sum} == a+b+cin exactly.
- Held outputs: sum and cout are stable from DONE until the next accepted start, at which point sum clears to 0.
- The counter is clog2(WIDTH) bits wide; no wrap occurs, because cnt is reset on every accept.

Optional Feature:
- Macro: SERIAL_ADD_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit): signed two's-complement overflow = carry into MSB XOR carry out of MSB.
  - ovf is registered on the same edge as cout, reset to 0, and holds with sum.
- When undefined: port absent; no extra state.

Decomposition:
- Package serial_add_pkg holds:
  - The state enum type (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - The default width constant (8).
- One sub-module, serial_fa_cell: combinational 1-bit full adder.
  - Built from two half_adder instances plus an OR for carry.
  - Ports a, b, cin, s, cout.
  - Instantiated once in serial_add_ctrl.

Test Plan:
- Reset: hold rst for 2 cycles, then release -> busy=0, done=0, sum=0, cout=0; no done with start=0 for 20 cycles.
- Basic add, WIDTH=8: a=8'h35, b=8'h0A, cin=0, pulse start -> busy for 8 cycles; done on cycle 9 after start; sum=8'h3F, cout=0.
- Carry chain: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Busy rejection: start a=1, b=2; while in RUN, assert start with a=8'h80, b=8'h80 -> result sum=8'h03 and a single done pulse.
- Mid-operation reset: assert rst on the 4th RUN cycle -> next cycle busy=0, sum=0; no done. Then a new start with a=8'h10, b=8'h20 -> sum=8'h30.
- With SERIAL_ADD_OVF_EN: a=8'h7F, b=8'h01 -> sum=8'h80, cout=0, ovf=1. a=8'h80, b=8'h80 -> sum=8'h00, cout=1, ovf=1.
